// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter onto one synchronous
// request/response memory bus. A single downstream transaction is in flight
// at a time. The winner's address, write data, strobe and operation are
// registered at grant, so the downstream bus stays stable for the whole access.
// Optional build macro MEM_ARB_TIMEOUT_EN: abort a downstream access that has
// not completed after TIMEOUT_CYCLES. The requester then gets 0xDEADBEEF and
// the sticky timeout_error flag is set.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s0_read_request,
  input  logic                      s0_write_request,
  input  logic [ADDR_WIDTH-1:0]     s0_address,
  input  logic [DATA_WIDTH-1:0]     s0_write_data,
  input  logic [DATA_WIDTH/8-1:0]   s0_write_strobe,
  output logic [DATA_WIDTH-1:0]     s0_read_data,
  output logic                      s0_read_response,
  output logic                      s0_write_response,
  input  logic                      s1_read_request,
  input  logic                      s1_write_request,
  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic [DATA_WIDTH-1:0]     s1_write_data,
  input  logic [DATA_WIDTH/8-1:0]   s1_write_strobe,
  output logic [DATA_WIDTH-1:0]     s1_read_data,
  output logic                      s1_read_response,
  output logic                      s1_write_response,
  output logic                      m_read_request,
  output logic                      m_write_request,
  output logic [ADDR_WIDTH-1:0]     m_address,
  output logic [DATA_WIDTH-1:0]     m_write_data,
  output logic [DATA_WIDTH/8-1:0]   m_write_strobe,
  input  logic [DATA_WIDTH-1:0]     m_read_data,
  input  logic                      m_read_response,
  input  logic                      m_write_response,
  output logic                      busy,
  output logic                      timeout_error
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Elaboration-time sanity checks on the configuration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("mem_bus_arbiter: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_q, gnt_d;
  logic                  op_wr_q, op_wr_d;
  logic                  m_rd_req_q, m_rd_req_d;
  logic                  m_wr_req_q, m_wr_req_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_WIDTH-1:0] m_strb_q, m_strb_d;
  logic [DATA_WIDTH-1:0] s0_rdata_q, s0_rdata_d;
  logic [DATA_WIDTH-1:0] s1_rdata_q, s1_rdata_d;
  logic                  s0_rd_rsp_q, s0_rd_rsp_d;
  logic                  s0_wr_rsp_q, s0_wr_rsp_d;
  logic                  s1_rd_rsp_q, s1_rd_rsp_d;
  logic                  s1_wr_rsp_q, s1_wr_rsp_d;

  logic                  req0, req1;
  logic                  win;
  logic                  win_wr;
  logic                  done;
  logic                  expire;
  logic [DATA_WIDTH-1:0] rdata_ret;

  // Request decode, round-robin winner selection and completion detect.
  // A tie goes to the port that was not granted last; a port with both read
  // and write raised presents its write first.
  always_comb begin
    req0 = s0_read_request | s0_write_request;
    req1 = s1_read_request | s1_write_request;
    if (req0 && req1) begin
      win = ~last_grant_q;
    end else begin
      win = req1;
    end
    win_wr = win ? s1_write_request : s0_write_request;
    // Only the response type matching the issued op completes it.
    done   = op_wr_q ? m_write_response : m_read_response;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int          CNT_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEADBEEF;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // 0xDEADBEEF repeated (or truncated) to fill DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] timeout_fill();
    logic [DATA_WIDTH-1:0] fill;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fill[i] = TIMEOUT_PATTERN[i % 32];
    end
    return fill;
  endfunction

  // Wait counter: cleared in IDLE, counts ISSUE cycles without completion.
  // The abort fires in the ISSUE cycle where the count reaches TIMEOUT_CYCLES.
  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    expire        = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == ST_ISSUE) && !done) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
        expire        = 1'b1;
        timeout_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rdata_ret = done ? m_read_data : timeout_fill();
  end

  // Timeout counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_error = timeout_err_q;
`else
  // Without the timeout option the arbiter waits for the downstream forever.
  always_comb begin
    expire    = 1'b0;
    rdata_ret = m_read_data;
  end

  assign timeout_error = 1'b0;
`endif

  // FSM next-state, grant latching, downstream request and requester responses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_wr_d      = op_wr_q;
    m_rd_req_d   = m_rd_req_q;
    m_wr_req_d   = m_wr_req_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_strb_d     = m_strb_q;
    s0_rdata_d   = s0_rdata_q;
    s1_rdata_d   = s1_rdata_q;
    s0_rd_rsp_d  = 1'b0;
    s0_wr_rsp_d  = 1'b0;
    s1_rd_rsp_d  = 1'b0;
    s1_wr_rsp_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d        = win;
          last_grant_d = win;
          op_wr_d      = win_wr;
          m_addr_d     = win ? s1_address    : s0_address;
          m_wdata_d    = win ? s1_write_data : s0_write_data;
          m_strb_d     = win ? s1_write_strobe : s0_write_strobe;
          m_wr_req_d   = win_wr;
          m_rd_req_d   = ~win_wr;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (done || expire) begin
          m_rd_req_d = 1'b0;
          m_wr_req_d = 1'b0;
          state_d    = ST_RESP;
          if (op_wr_q) begin
            if (gnt_q) begin
              s1_wr_rsp_d = 1'b1;
            end else begin
              s0_wr_rsp_d = 1'b1;
            end
          end else if (gnt_q) begin
            s1_rd_rsp_d = 1'b1;
            s1_rdata_d  = rdata_ret;
          end else begin
            s0_rd_rsp_d = 1'b1;
            s0_rdata_d  = rdata_ret;
          end
        end
      end

      // Response pulse is visible for this single cycle.
      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_wr_q      <= 1'b0;
      m_rd_req_q   <= 1'b0;
      m_wr_req_q   <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_strb_q     <= '0;
      s0_rdata_q   <= '0;
      s1_rdata_q   <= '0;
      s0_rd_rsp_q  <= 1'b0;
      s0_wr_rsp_q  <= 1'b0;
      s1_rd_rsp_q  <= 1'b0;
      s1_wr_rsp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_wr_q      <= op_wr_d;
      m_rd_req_q   <= m_rd_req_d;
      m_wr_req_q   <= m_wr_req_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_strb_q     <= m_strb_d;
      s0_rdata_q   <= s0_rdata_d;
      s1_rdata_q   <= s1_rdata_d;
      s0_rd_rsp_q  <= s0_rd_rsp_d;
      s0_wr_rsp_q  <= s0_wr_rsp_d;
      s1_rd_rsp_q  <= s1_rd_rsp_d;
      s1_wr_rsp_q  <= s1_wr_rsp_d;
    end
  end

  assign m_read_request    = m_rd_req_q;
  assign m_write_request   = m_wr_req_q;
  assign m_address         = m_addr_q;
  assign m_write_data      = m_wdata_q;
  assign m_write_strobe    = m_strb_q;
  assign s0_read_data      = s0_rdata_q;
  assign s1_read_data      = s1_rdata_q;
  assign s0_read_response  = s0_rd_rsp_q;
  assign s0_write_response = s0_wr_rsp_q;
  assign s1_read_response  = s1_rd_rsp_q;
  assign s1_write_response = s1_wr_rsp_q;
  assign busy              = (state_q == ST_ISSUE) || (state_q == ST_RESP);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed transactions, a downstream memory
// model checking the m_* bus, and a scoreboard monitor on requester responses.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_read_request, s0_write_request;
  logic [31:0] s0_address, s0_write_data;
  logic [3:0]  s0_write_strobe;
  logic [31:0] s0_read_data;
  logic        s0_read_response, s0_write_response;
  logic        s1_read_request, s1_write_request;
  logic [31:0] s1_address, s1_write_data;
  logic [3:0]  s1_write_strobe;
  logic [31:0] s1_read_data;
  logic        s1_read_response, s1_write_response;
  logic        m_read_request, m_write_request;
  logic [31:0] m_address, m_write_data;
  logic [3:0]  m_write_strobe;
  logic [31:0] m_read_data;
  logic        m_read_response, m_write_response;
  logic        busy, timeout_error;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .s0_read_request(s0_read_request), .s0_write_request(s0_write_request),
    .s0_address(s0_address), .s0_write_data(s0_write_data),
    .s0_write_strobe(s0_write_strobe), .s0_read_data(s0_read_data),
    .s0_read_response(s0_read_response), .s0_write_response(s0_write_response),
    .s1_read_request(s1_read_request), .s1_write_request(s1_write_request),
    .s1_address(s1_address), .s1_write_data(s1_write_data),
    .s1_write_strobe(s1_write_strobe), .s1_read_data(s1_read_data),
    .s1_read_response(s1_read_response), .s1_write_response(s1_write_response),
    .m_read_request(m_read_request), .m_write_request(m_write_request),
    .m_address(m_address), .m_write_data(m_write_data),
    .m_write_strobe(m_write_strobe), .m_read_data(m_read_data),
    .m_read_response(m_read_response), .m_write_response(m_write_response),
    .busy(busy), .timeout_error(timeout_error)
  );

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    int          delay;   // 255 = never respond
    bit          wrong;   // pulse the other response type first
  } ds_t;

  rsp_t exp_q[$];
  ds_t  ds_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_resp_cyc = 0;
  bit ds_abort = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic exp_push(int port, bit wr, logic [31:0] rdata);
    rsp_t e;
    e.port = port; e.wr = wr; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic ds_push(bit wr, logic [31:0] addr, logic [31:0] wdata,
                         logic [3:0] strb, logic [31:0] rdata, int delay, bit wrong);
    ds_t d;
    d.wr = wr; d.addr = addr; d.wdata = wdata; d.strb = strb;
    d.rdata = rdata; d.delay = delay; d.wrong = wrong;
    ds_q.push_back(d);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled 1 time unit after the active edge.
  logic [1:0]  rresp, wresp;
  logic [31:0] rdat [2];
  logic [31:0] last_rd [2];
  rsp_t        mon_e;
  assign rresp   = {s1_read_response, s0_read_response};
  assign wresp   = {s1_write_response, s0_write_response};
  assign rdat[0] = s0_read_data;
  assign rdat[1] = s1_read_data;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rresp[p] || wresp[p]) begin
          last_resp_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_response: actual port=%0d rd=%0b wr=%0b required none",
                     p, rresp[p], wresp[p]);
          end else begin
            mon_e = exp_q.pop_front();
            check("resp_port", p, mon_e.port);
            check("resp_type", {rresp[p], wresp[p]}, {!mon_e.wr, mon_e.wr});
            if (!mon_e.wr) begin
              check("resp_rdata", rdat[p], mon_e.rdata);
              last_rd[p] = mon_e.rdata;
            end else begin
              check("resp_rdata_hold", rdat[p], last_rd[p]);
            end
          end
        end
      end
    end
  end

  // Downstream memory model: checks the issued bus, answers after a delay.
  initial begin
    ds_t d;
    bit  aborted;
    int  waited;
    m_read_response  = 1'b0;
    m_write_response = 1'b0;
    m_read_data      = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset && (m_read_request || m_write_request)) begin
        if (ds_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ds_unexpected: actual addr=0x%0h required no request", m_address);
        end else begin
          d = ds_q.pop_front();
          check("ds_op", {m_write_request, m_read_request}, {d.wr, !d.wr});
          check("ds_addr", m_address, d.addr);
          if (d.wr) begin
            check("ds_wdata", m_write_data, d.wdata);
            check("ds_strb", m_write_strobe, d.strb);
          end
          if (d.wrong) begin
            if (d.wr) m_read_response = 1'b1;
            else      m_write_response = 1'b1;
          end
          aborted = 1'b0;
          if (d.delay == 255) begin
            waited = 0;
            while ((m_read_request || m_write_request) && waited < 64 && !ds_abort) begin
              @(negedge clk);
              waited++;
            end
            check("ds_timeout_drop", {m_read_request, m_write_request}, 2'b00);
          end else begin
            for (int i = 0; i < d.delay; i++) begin
              @(negedge clk);
              m_read_response  = 1'b0;
              m_write_response = 1'b0;
              if (ds_abort) begin
                aborted = 1'b1;
                break;
              end
            end
            if (!aborted) begin
              check("ds_stable",
                    {m_address, m_write_data, m_write_strobe, m_write_request, m_read_request},
                    {d.addr, d.wdata, d.strb, d.wr, !d.wr});
              if (d.wr) begin
                m_write_response = 1'b1;
              end else begin
                m_read_response = 1'b1;
                m_read_data     = d.rdata;
              end
              @(negedge clk);
              m_read_response  = 1'b0;
              m_write_response = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic set_req(int p, bit rd, bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] st);
    if (p == 0) begin
      s0_read_request = rd; s0_write_request = wr;
      s0_address = a; s0_write_data = wd; s0_write_strobe = st;
    end else begin
      s1_read_request = rd; s1_write_request = wr;
      s1_address = a; s1_write_data = wd; s1_write_strobe = st;
    end
  endtask

  // Requester side: drop each request once its response is seen, until idle.
  task automatic run_until_idle(string name, int maxc);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
      if (s0_read_response)  s0_read_request  = 1'b0;
      if (s0_write_response) s0_write_request = 1'b0;
      if (s1_read_response)  s1_read_request  = 1'b0;
      if (s1_write_response) s1_write_request = 1'b0;
      if (!(s0_read_request || s0_write_request || s1_read_request || s1_write_request) && !busy)
        done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int n;
    reset = 1'b1;
    set_req(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_req(1, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_mreq", {m_read_request, m_write_request}, 2'b00);
    check("rst_mbus", {m_address, m_write_data, m_write_strobe}, 68'h0);
    check("rst_resp", {rresp, wresp}, 4'h0);
    check("rst_rdata", {s0_read_data, s1_read_data}, 64'h0);
    check("rst_timeout", timeout_error, 1'b0);
    @(negedge clk);

    // Simultaneous requests after reset: s0, s1, then again s0, s1.
    ds_push(0, 32'h10, 32'h0, 4'h0, 32'hA0A00001, 1, 0);
    ds_push(0, 32'h14, 32'h0, 4'h0, 32'hB0B00002, 0, 0);
    exp_push(0, 0, 32'hA0A00001);
    exp_push(1, 0, 32'hB0B00002);
    set_req(0, 1, 0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1, 0, 32'h14, 32'h0, 4'h0);
    run_until_idle("rr_round1_done", 40);
    ds_push(0, 32'h18, 32'h0, 4'h0, 32'hA0A00003, 0, 0);
    ds_push(1, 32'h1C, 32'h11112222, 4'hF, 32'h0, 1, 0);
    exp_push(0, 0, 32'hA0A00003);
    exp_push(1, 1, 32'h0);
    set_req(0, 1, 0, 32'h18, 32'h0, 4'h0);
    set_req(1, 0, 1, 32'h1C, 32'h11112222, 4'hF);
    run_until_idle("rr_round2_done", 40);

    // s0 read, response 2 cycles after issue, stray write response ignored.
    ds_push(0, 32'h100, 32'h0, 4'h0, 32'h12345678, 2, 1);
    exp_push(0, 0, 32'h12345678);
    c = cyc;
    set_req(0, 1, 0, 32'h100, 32'h0, 4'h0);
    run_until_idle("s0_read_done", 40);
    check("s0_read_latency", last_resp_cyc - c, 4);

    // s1 write with partial strobe.
    ds_push(1, 32'h200, 32'hCAFEBABE, 4'b0011, 32'h0, 3, 0);
    exp_push(1, 1, 32'h0);
    set_req(1, 0, 1, 32'h200, 32'hCAFEBABE, 4'b0011);
    run_until_idle("s1_write_done", 40);

    // s0 read and write together: write first, then read.
    ds_push(1, 32'h300, 32'h55AA55AA, 4'hF, 32'h0, 1, 0);
    ds_push(0, 32'h300, 32'h55AA55AA, 4'hF, 32'h0BADF00D, 0, 0);
    exp_push(0, 1, 32'h0);
    exp_push(0, 0, 32'h0BADF00D);
    set_req(0, 1, 1, 32'h300, 32'h55AA55AA, 4'hF);
    run_until_idle("s0_rw_done", 40);
    repeat (2) @(negedge clk);
    check("s0_rdata_hold", s0_read_data, 32'h0BADF00D);

    // Reset while ISSUE is waiting; then a fresh s1 read.
    ds_push(0, 32'h400, 32'h0, 4'h0, 32'h44444444, 10, 0);
    set_req(0, 1, 0, 32'h400, 32'h0, 4'h0);
    n = 0;
    while (!m_read_request && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midrst_issue_seen", m_read_request, 1'b1);
    ds_abort = 1'b1;
    s0_read_request = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_mreq", {m_read_request, m_write_request}, 2'b00);
    check("midrst_mbus", {m_address, m_write_data, m_write_strobe}, 68'h0);
    check("midrst_resp", {rresp, wresp}, 4'h0);
    check("midrst_rdata", {s0_read_data, s1_read_data}, 64'h0);
    @(negedge clk);
    ds_abort = 1'b0;
    ds_push(0, 32'h500, 32'h0, 4'h0, 32'h5A5A0005, 1, 0);
    exp_push(1, 0, 32'h5A5A0005);
    set_req(1, 1, 0, 32'h500, 32'h0, 4'h0);
    run_until_idle("post_rst_s1_done", 40);

`ifdef MEM_ARB_TIMEOUT_EN
    // Downstream never answers: abort with 0xDEADBEEF.
    ds_push(0, 32'h600, 32'h0, 4'h0, 32'h0, 255, 0);
    exp_push(0, 0, 32'hDEADBEEF);
    c = cyc;
    set_req(0, 1, 0, 32'h600, 32'h0, 4'h0);
    run_until_idle("timeout_done", 60);
    check("timeout_latency", last_resp_cyc - c, 18);
    check("timeout_flag", timeout_error, 1'b1);
    repeat (3) @(negedge clk);
    check("timeout_sticky", timeout_error, 1'b1);
`else
    check("timeout_tied_low", timeout_error, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    check("ds_queue_empty", ds_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
